// File: rtl/hilo_muldiv_ctrl.sv
// Hi/Lo multiply-divide unit: 32-cycle signed shift-add multiply and restoring divide
// with direct mthi/mtlo writes, one-cycle done pulse and divide-by-zero flag.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state  | meaning
  // S_IDLE | accept start requests and mthi/mtlo writes
  // S_MULT | 32 shift-add steps on operand magnitudes
  // S_DIV  | 32 restoring shift-subtract steps on operand magnitudes
  // S_FIX  | sign correction, hi/lo written on exit
  // S_DONE | one-cycle done pulse (div_zero here for b == 0)
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opnd_q, opnd_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] mult_sum;
  logic [31:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    mag_a     = a[31] ? -a : a;
    mag_b     = b[31] ? -b : b;
    // multiply: acc_hi holds the upper partial product, acc_lo the shifting multiplier
    mult_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    // divide: acc_hi holds the remainder, acc_lo shifts dividend out and quotient in
    div_shift = {acc_hi_q[30:0], acc_lo_q[31]};
    div_diff  = {1'b0, div_shift} - {1'b0, opnd_q};
    prod_fix  = (sign_a_q ^ sign_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
    rem_fix   = sign_a_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    is_div_d   = is_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d  = S_MULT;
          busy_d   = 1'b1;
          cnt_d    = 5'd31;
          is_div_d = 1'b0;
          sign_a_d = a[31];
          sign_b_d = b[31];
          acc_hi_d = 32'd0;
          acc_lo_d = mag_b;
          opnd_d   = mag_a;
        end else if (start_div) begin
          if (b == 32'd0) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d  = S_DIV;
            busy_d   = 1'b1;
            cnt_d    = 5'd31;
            is_div_d = 1'b1;
            sign_a_d = a[31];
            sign_b_d = b[31];
            acc_hi_d = 32'd0;
            acc_lo_d = mag_a;
            opnd_d   = mag_b;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_MULT: begin
        busy_d               = 1'b1;
        {acc_hi_d, acc_lo_d} = {mult_sum, acc_lo_q[31:1]};
        cnt_d                = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FIX;
      end
      S_DIV: begin
        busy_d = 1'b1;
        if (!div_diff[32]) begin
          acc_hi_d = div_diff[31:0];
          acc_lo_d = {acc_lo_q[30:0], 1'b1};
        end else begin
          acc_hi_d = div_shift;
          acc_lo_d = {acc_lo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      opnd_q     <= 32'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: hand-computed results, latency, div-by-zero,
// mid-operation reset and ignored requests.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, start_mult, start_div, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  hilo_muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
  endtask

  // Drive a start for one edge; returns in cycle 1 after the accepting edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
    start_mult = m; start_div = d; a = av; b = bv;
    tick();
    start_mult = 1'b0; start_div = 1'b0;
  endtask

  // Called in cycle 1; walks cycles 1..33 expecting busy, then checks done in cycle 34.
  task automatic expect_done(input string tag, input logic perturb,
                             input logic [31:0] eh, input logic [31:0] el);
    int bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (perturb) begin
        start_mult = 1'b1; start_div = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        wdata = 32'hDEAD; a = 32'h55; b = 32'h0;
      end
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    chk({tag, " busy_window_errs"}, bad, 0);
    chk({tag, " done@34"}, {31'd0, done}, 1);
    chk({tag, " busy@34"}, {31'd0, busy}, 0);
    chk({tag, " div_zero@34"}, {31'd0, div_zero}, 0);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    start_mult = 1'b0; start_div = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    tick();
    chk({tag, " done@35"}, {31'd0, done}, 0);
    chk({tag, " hi@35"}, hi, eh);
    chk({tag, " lo@35"}, lo, el);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = 32'd0; b = 32'd0; wdata = 32'd0;
    tick();
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset div_zero", {31'd0, div_zero}, 0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 7 * -3 = -21
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    expect_done("mul_7x-3", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);

    // -7 / 2 -> q=-3 r=-1
    start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    expect_done("div_-7/2", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // 100 / -7 -> q=-14 r=2
    start_op(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9);
    expect_done("div_100/-7", 1'b0, 32'd2, 32'hFFFFFFF2);

    // 0x12345678 * 0x10
    start_op(1'b1, 1'b0, 32'h12345678, 32'h10);
    expect_done("mul_pos", 1'b0, 32'h1, 32'h23456780);

    // mthi/mtlo, separately and together
    hi_we = 1'b1; wdata = 32'h11; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
    lo_we = 1'b0;
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h99; tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("both_we hi", hi, 32'h99);
    chk("both_we lo", lo, 32'h99);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11; tick();
    lo_we = 1'b0; hi_we = 1'b0; wdata = 32'h22; lo_we = 1'b1; tick();
    lo_we = 1'b0;

    // divide by zero: done+flag in cycle 1, hi/lo untouched, no busy
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    chk("dz done@1", {31'd0, done}, 1);
    chk("dz flag@1", {31'd0, div_zero}, 1);
    chk("dz busy@1", {31'd0, busy}, 0);
    chk("dz hi", hi, 32'h11);
    chk("dz lo", lo, 32'h22);
    tick();
    chk("dz done@2", {31'd0, done}, 0);
    chk("dz flag@2", {31'd0, div_zero}, 0);
    chk("dz busy@2", {31'd0, busy}, 0);

    // minimum-value corner cases
    start_op(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    expect_done("mul_min", 1'b0, 32'h40000000, 32'h0);
    start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    expect_done("div_min/-1", 1'b0, 32'h0, 32'h80000000);

    // requests and writes during an active multiply are ignored
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    expect_done("mul_perturbed", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);

    // simultaneous starts: multiply wins (6*3=18, divide would give 2)
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    expect_done("both_starts", 1'b0, 32'h0, 32'h12);

    // reset in cycle 10 of a multiply
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid busy@11", {31'd0, busy}, 0);
    chk("rst_mid hi@11", hi, 32'd0);
    chk("rst_mid lo@11", lo, 32'd0);
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) seen_done++;
      tick();
    end
    chk("rst_mid no_done", seen_done, 0);
    chk("rst_mid lo_held", lo, 32'd0);
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    expect_done("mul_after_rst", 1'b0, 32'h0, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
